lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the read and write ports of the 64-bit data memory instance (DATA_MEM=1, async read, write on clock edge). It accepts byte, half and word load/store requests from the core's MEM stage over a valid/ready handshake. It extracts and sign- or zero-extends load data, and performs read-merge-write for sub-dword stores. Misaligned and out-of-range accesses are rejected with an error response and never touch memory.

Parameters:
MEM_SIZE, 4096, depth of attached data memory in 64-bit dwords
MEM_WIDTH, $clog2(MEM_SIZE), dword index width; matches the memory's address ports
XLEN, 32, core data width

Ports:
clk  input  1  clock
aresetn  input  1  reset; synchronous, active-low (sampled on posedge clk only)
req_valid  input  1  core request valid
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address
req_size  input  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned  input  1  zero-extend load result (LBU/LHU)
req_wdata  input  XLEN  store data, right-aligned
resp_valid  output  1  response valid
resp_ready  input  1  core accepts response
resp_rdata  output  XLEN  load result; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal-size access
mem_rd_addr  output  MEM_WIDTH  to memory rd_addr
mem_rd_data  input  64  from memory rd_data (combinational)
mem_wr_addr  output  MEM_WIDTH  to memory wr_addr
mem_wr_data  output  64  to memory wr_data
mem_wr_en  output  1  to memory wr_en

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (aresetn=0 at a posedge) forces IDLE. Reset values: resp_valid=0, resp_err=0, resp_rdata=0, all internal request registers 0.
- req_ready=1 only in IDLE. On a handshake (req_valid & req_ready), register we/addr/size/unsigned/wdata, compute err and go to ACCESS.
- err conditions:
  - size==3
  - size==1 with addr[0]=1
  - size==2 with addr[1:0]!=0
  - addr[XLEN-1:MEM_WIDTH+3]!=0
- Address split: dword index = addr[MEM_WIDTH+2:3], byte offset = addr[2:0]. mem_rd_addr and mem_wr_addr are both driven from the registered index in every state.
- ACCESS, load, no err: select bytes from mem_rd_data at offset*8; sign-extend from bit 7/15 unless unsigned (word needs no extension). Register the result into resp_rdata. Go to RESP.
- ACCESS, store, no err: mem_wr_data = mem_rd_data with the 1/2/4 addressed bytes replaced by the low bytes of wdata; other bytes are preserved. mem_wr_en=1 for exactly this one cycle. resp_rdata=0. Go to RESP.
- ACCESS with err: mem_wr_en=0, resp_err=1, resp_rdata=0. Go to RESP.
- mem_wr_en = (state==ACCESS) & we & ~err & aresetn (combinational). A reset asserted during ACCESS suppresses the write.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready. On resp_valid & resp_ready, return to IDLE next cycle; resp_valid and resp_err clear.
- Latency: handshake at cycle N gives resp_valid at N+2. Maximum throughput is one request per 3 cycles.
- Ordering: a store's write lands at the end of its ACCESS cycle. Any later request reaches ACCESS at least 3 cycles later, so a load always sees the prior store. No forwarding is required.
- Reset in RESP drops the pending response without handshake.

Optional Feature:
LSU_PERF_CNT_EN
- Defined: adds outputs perf_loads, perf_stores and perf_errs (32 bits each).
  - Each counter increments by 1 on the RESP handshake of a successful load, a successful store, or any error respectively.
  - Counters wrap at 2^32 and are reset to 0 by aresetn.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Preload dword0=0x8877665544332211. Load byte at 0x7 signed -> resp_rdata=0xFFFFFF88; unsigned -> 0x00000088; resp_valid 2 cycles after handshake.
- Same preload. Load half at 0x2 signed -> 0x00004433; load word at 0x4 -> 0x88776655.
- Store word 0xDEADBEEF at 0x4: mem_wr_en high exactly 1 cycle with wr_data=0xDEADBEEF44332211. A following load word at 0x4 returns 0xDEADBEEF.
- Error cases, each giving resp_err=1, mem_wr_en never asserted, dword0 unchanged:
  - store word at 0x2
  - store half at 0x1
  - size=3
  - load at 0x8000 (MEM_SIZE=4096)
- Backpressure: hold resp_ready=0 for 3 cycles in RESP -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout. Release -> IDLE next cycle.
- Assert aresetn=0 during a store's ACCESS cycle -> no write, FSM in IDLE, resp_valid=0. With LSU_PERF_CNT_EN, counters read 0 afterwards and count 1/1/1 after one load, one store and one error.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a 64-bit data memory: byte/half/word loads with extension,
// read-merge-write stores, error rejection. Optional perf counters: LSU_PERF_CNT_EN.
module lsu_mem_ctrl #(
    parameter int MEM_SIZE  = 4096,
    parameter int MEM_WIDTH = $clog2(MEM_SIZE),
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic [MEM_WIDTH-1:0] mem_rd_addr,
    input  logic [63:0]          mem_rd_data,
    output logic [MEM_WIDTH-1:0] mem_wr_addr,
    output logic [63:0]          mem_wr_data,
    output logic                 mem_wr_en
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_loads,
    output logic [31:0]          perf_stores,
    output logic [31:0]          perf_errs
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_req_ready;
    logic                   r_we;
    logic [MEM_WIDTH+2:0]   r_addr;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [XLEN-1:0]        r_wdata;
    logic                   r_err;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic [XLEN-1:0]        r_resp_rdata;

    logic [5:0]             w_shamt;
    logic [31:0]            w_rd_shift;
    logic                   w_sign;
    logic [XLEN-1:0]        w_load;
    logic [63:0]            w_mask;

    // Misalignment, illegal size, or address bits beyond the attached memory.
    function automatic logic f_req_err(input logic [XLEN-1:0] addr, input logic [1:0] size);
        logic v_err;
        case (size)
            2'd0:    v_err = 1'b0;
            2'd1:    v_err = addr[0];
            2'd2:    v_err = (addr[1:0] != 2'b00);
            default: v_err = 1'b1;
        endcase
        if ((addr >> (MEM_WIDTH + 3)) != {XLEN{1'b0}}) begin
            v_err = 1'b1;
        end else begin
            v_err = v_err;
        end
        return v_err;
    endfunction

    assign w_shamt     = {r_addr[2:0], 3'b000};
    assign mem_rd_addr = r_addr[MEM_WIDTH+2:3];
    assign mem_wr_addr = r_addr[MEM_WIDTH+2:3];
    assign mem_wr_en   = (r_state == ST_ACCESS) & r_we & ~r_err & aresetn;

    // Load data extraction and sign/zero extension.
    always_comb begin
        w_rd_shift = 32'(mem_rd_data >> w_shamt);
        w_sign     = 1'b0;
        w_load     = {XLEN{1'b0}};
        case (r_size)
            2'd0: begin
                w_sign = w_rd_shift[7] & ~r_unsigned;
                w_load = {{(XLEN-8){w_sign}}, w_rd_shift[7:0]};
            end
            2'd1: begin
                w_sign = w_rd_shift[15] & ~r_unsigned;
                w_load = {{(XLEN-16){w_sign}}, w_rd_shift[15:0]};
            end
            2'd2: begin
                w_sign = 1'b0;
                w_load = XLEN'(w_rd_shift);
            end
            default: begin
                w_sign = 1'b0;
                w_load = {XLEN{1'b0}};
            end
        endcase
    end

    // Store merge: replace only the addressed bytes of the current dword.
    always_comb begin
        case (r_size)
            2'd0:    w_mask = 64'h0000_0000_0000_00FF << w_shamt;
            2'd1:    w_mask = 64'h0000_0000_0000_FFFF << w_shamt;
            2'd2:    w_mask = 64'h0000_0000_FFFF_FFFF << w_shamt;
            default: w_mask = 64'h0000_0000_0000_0000;
        endcase
        mem_wr_data = (mem_rd_data & ~w_mask) | ((64'(r_wdata) << w_shamt) & w_mask);
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= {(MEM_WIDTH+3){1'b0}};
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= {XLEN{1'b0}};
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr[MEM_WIDTH+2:0];
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_wdata     <= req_wdata;
                        r_err       <= f_req_err(req_addr, req_size);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_err;
                    r_resp_rdata <= (!r_we && !r_err) ? w_load : {XLEN{1'b0}};
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] r_perf_loads;
    logic [31:0] r_perf_stores;
    logic [31:0] r_perf_errs;

    // Outcome counters advance on the response handshake only.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_perf_loads  <= 32'd0;
            r_perf_stores <= 32'd0;
            r_perf_errs   <= 32'd0;
        end else if ((r_state == ST_RESP) && resp_ready) begin
            if (r_resp_err) begin
                r_perf_errs <= r_perf_errs + 32'd1;
            end else if (r_we) begin
                r_perf_stores <= r_perf_stores + 32'd1;
            end else begin
                r_perf_loads <= r_perf_loads + 32'd1;
            end
        end
    end

    assign perf_loads  = r_perf_loads;
    assign perf_stores = r_perf_stores;
    assign perf_errs   = r_perf_errs;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a behavioural 64-bit data memory.
module tb_lsu_mem_ctrl;

    localparam int MEM_SIZE  = 4096;
    localparam int MEM_WIDTH = 12;
    localparam int XLEN      = 32;

    logic                 clk;
    logic                 aresetn;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [XLEN-1:0]      req_addr;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [XLEN-1:0]      req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_rdata;
    logic                 resp_err;
    logic [MEM_WIDTH-1:0] mem_rd_addr;
    logic [63:0]          mem_rd_data;
    logic [MEM_WIDTH-1:0] mem_wr_addr;
    logic [63:0]          mem_wr_data;
    logic                 mem_wr_en;
`ifdef LSU_PERF_CNT_EN
    logic [31:0]          perf_loads;
    logic [31:0]          perf_stores;
    logic [31:0]          perf_errs;
`endif

    int n_checks;
    int n_fail;

    logic [63:0]          mem [0:MEM_SIZE-1];
    logic                 pre_en;
    logic [MEM_WIDTH-1:0] pre_addr;
    logic [63:0]          pre_data;

    int                   wr_count;
    logic [63:0]          last_wr_data;
    logic [MEM_WIDTH-1:0] last_wr_addr;

    lsu_mem_ctrl #(
        .MEM_SIZE (MEM_SIZE),
        .MEM_WIDTH(MEM_WIDTH),
        .XLEN     (XLEN)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errs   (perf_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: async read, write on clock edge; bench preload port has priority.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rd_data = mem[mem_rd_addr];

    // Write monitor: one sample per cycle, away from the active edge.
    initial wr_count = 0;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_count     = wr_count + 1;
            last_wr_data = mem_wr_data;
            last_wr_addr = mem_wr_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [MEM_WIDTH-1:0] a, input logic [63:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // One full transaction; hold = cycles resp_ready stays low once resp_valid is seen.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge clk);
        check({tag, "_req_ready"}, req_ready, 1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 8);
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_latency"}, n, 2);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, resp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, resp_valid, 1);
            check({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, "_hold_err"}, resp_err, exp_err);
            check({tag, "_hold_req_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_done_valid"}, resp_valid, 0);
        check({tag, "_done_err"}, resp_err, 0);
        check({tag, "_done_ready"}, req_ready, 1);
    endtask

    initial begin
        int base;
        n_checks     = 0;
        n_fail       = 0;
        aresetn      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;
        pre_en       = 1'b0;
        pre_addr     = '0;
        pre_data     = 64'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_en", mem_wr_en, 0);
        aresetn = 1'b1;

        preload(12'd0, 64'h8877_6655_4433_2211);
        preload(12'd1, 64'h0);

        issue("lb7s",  1'b0, 32'h7, 2'd0, 1'b0, 32'h0, 0, 32'hFFFF_FF88, 1'b0);
        issue("lbu7",  1'b0, 32'h7, 2'd0, 1'b1, 32'h0, 0, 32'h0000_0088, 1'b0);
        issue("lh2s",  1'b0, 32'h2, 2'd1, 1'b0, 32'h0, 0, 32'h0000_4433, 1'b0);
        issue("lh6s",  1'b0, 32'h6, 2'd1, 1'b0, 32'h0, 0, 32'hFFFF_8877, 1'b0);
        issue("lhu6",  1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 0, 32'h0000_8877, 1'b0);
        issue("lw4",   1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, 32'h8877_6655, 1'b0);

        base = wr_count;
        issue("sw4",   1'b1, 32'h4, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        check("sw4_wr_cycles", wr_count - base, 1);
        check("sw4_wr_data", last_wr_data, 64'hDEAD_BEEF_4433_2211);
        check("sw4_wr_addr", last_wr_addr, 0);
        check("sw4_mem0", mem[0], 64'hDEAD_BEEF_4433_2211);
        issue("lw4b",  1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

        base = wr_count;
        issue("sbd",   1'b1, 32'hD, 2'd0, 1'b0, 32'hFFFF_FF5A, 0, 32'h0, 1'b0);
        issue("sha",   1'b1, 32'hA, 2'd1, 1'b0, 32'h1234_BEEF, 0, 32'h0, 1'b0);
        check("sub_wr_cycles", wr_count - base, 2);
        check("sub_wr_addr", last_wr_addr, 1);
        check("sub_mem1", mem[1], 64'h0000_5A00_BEEF_0000);
        issue("lhua",  1'b0, 32'hA, 2'd1, 1'b1, 32'h0, 0, 32'h0000_BEEF, 1'b0);
        issue("lbd",   1'b0, 32'hD, 2'd0, 1'b0, 32'h0, 0, 32'h0000_005A, 1'b0);

        base = wr_count;
        issue("e_sw2",   1'b1, 32'h2,    2'd2, 1'b0, 32'h1234_5678, 0, 32'h0, 1'b1);
        issue("e_sh1",   1'b1, 32'h1,    2'd1, 1'b0, 32'h0000_FFFF, 0, 32'h0, 1'b1);
        issue("e_sz3",   1'b1, 32'h0,    2'd3, 1'b0, 32'hAAAA_AAAA, 0, 32'h0, 1'b1);
        issue("e_oor",   1'b0, 32'h8000, 2'd2, 1'b0, 32'h0,         0, 32'h0, 1'b1);
        issue("e_oor_s", 1'b1, 32'h8000, 2'd2, 1'b0, 32'h5555_5555, 0, 32'h0, 1'b1);
        check("err_wr_cycles", wr_count - base, 0);
        check("err_mem0", mem[0], 64'hDEAD_BEEF_4433_2211);

        issue("bp",     1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        issue("bp_err", 1'b0, 32'h3, 2'd1, 1'b0, 32'h0, 2, 32'h0, 1'b1);

        // Reset while a store sits in its access cycle.
        base = wr_count;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_wdata    = 32'h1111_2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        aresetn   = 1'b0;
        @(negedge clk);
        check("abort_wr_en", mem_wr_en, 0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_wr_cycles", wr_count - base, 0);
        check("abort_mem0", mem[0], 64'hDEAD_BEEF_4433_2211);

`ifdef LSU_PERF_CNT_EN
        check("perf_loads_rst", perf_loads, 0);
        check("perf_stores_rst", perf_stores, 0);
        check("perf_errs_rst", perf_errs, 0);
        issue("pl", 1'b0, 32'h0,  2'd2, 1'b0, 32'h0, 0, 32'h4433_2211, 1'b0);
        issue("ps", 1'b1, 32'h10, 2'd2, 1'b0, 32'h1,  0, 32'h0, 1'b0);
        issue("pe", 1'b0, 32'h1,  2'd1, 1'b0, 32'h0, 0, 32'h0, 1'b1);
        check("perf_loads", perf_loads, 1);
        check("perf_stores", perf_stores, 1);
        check("perf_errs", perf_errs, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
